controlador_carga_instrucoes: RTL and testbench
===============================================

# controlador_carga_instrucoes

Boot-load controller and port arbiter for the CPU's instruction memory. After reset it owns the memory's write and address ports and receives a program byte-by-byte from a host over a valid/ready handshake. It assembles 32-bit words and writes them at consecutive addresses, then hands the address port to the CPU's `pc` and enables the core. It also stops the core on HALT and supports reloading without a global reset.

## Interface
Parameters:
- `MEM_SIZE`, 30: instruction-memory depth in words; largest accepted program.
- `ADDR_WIDTH`, 26: memory address width, equal to `pc` width.

Ports:
- `clock`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: reset is asynchronous and active-high; the block returns to `TAM0` immediately.
- `host_dado`  in  8: program byte from the host.
- `host_valido`  in  1: `host_dado` is valid.
- `host_pronto`  out  1: block can accept a byte. A byte transfers on a cycle where `host_valido && host_pronto`.
- `recarregar`  in  1: request a new load; honoured only in `EXECUTA`, `PARADO` and `ERRO`.
- `cpu_halt`  in  1: core decoded HALT (opcode 6'b111111).
- `pc`  in  ADDR_WIDTH: fetch address from the core.
- `mem_endereco`  out  ADDR_WIDTH: address to instruction memory.
- `mem_dado`  out  32: write data to instruction memory.
- `mem_escrita`  out  1: write strobe, one cycle per word.
- `cpu_habilita`  out  1: core may advance `pc` and execute.
- `carga_erro`  out  1: the declared program size exceeded `MEM_SIZE`.

## Operation
- Stream format, all fields MSB-first:
  - 2-byte word count N.
  - Then N words of 4 bytes each.
- States and transitions:
  - `TAM0` → `TAM1`: on accepting the high byte of N.
  - `TAM1`: on accepting the low byte of N, go to:
    - `EXECUTA` if N = 0;
    - `ERRO` if N > `MEM_SIZE`;
    - `RECEBE` otherwise.
  - `RECEBE` → `ESCREVE`: after the 4th byte of a word is accepted. A 2-bit byte counter tracks progress; each byte shifts into the word register from the LSB side.
  - `ESCREVE`: `mem_escrita`=1 with `mem_endereco` = word index and `mem_dado` = assembled word.
    - Index increments after the write.
    - Go to `EXECUTA` if this was word N-1; otherwise return to `RECEBE`.
  - `EXECUTA`: `cpu_habilita`=1 and `mem_endereco`=`pc` (combinational mux).
    - `cpu_halt` → `PARADO`.
    - `recarregar` → `TAM0`.
    - If `cpu_halt` and `recarregar` are both high in the same cycle, `recarregar` wins.
  - `PARADO`: `cpu_habilita`=0 and `mem_endereco`=`pc`; `recarregar` → `TAM0`.
  - `ERRO`: `carga_erro`=1; `recarregar` → `TAM0`.
- `host_pronto` = 1 in `TAM0`, `TAM1` and `RECEBE`; 0 in all other states, so the host stalls during `ESCREVE`.
- Entering `TAM0` clears the word index, byte counter, N and `carga_erro`.
- Memory contents are not cleared: words beyond N keep their old values.
- `mem_endereco` outside `EXECUTA`/`PARADO` is the word index zero-extended to `ADDR_WIDTH`.

## Timing
- Reset values:
  - `host_pronto`=1 (state `TAM0`).
  - `mem_escrita`=0, `mem_dado`=0, `mem_endereco`=0, `cpu_habilita`=0, `carga_erro`=0.
- Each word costs at least 5 cycles: 4 byte transfers plus 1 `ESCREVE` cycle.
- `cpu_habilita` rises on the cycle after the last `ESCREVE`. For N=0 it rises on the cycle after the low byte of N is accepted.
- `cpu_habilita` falls on the cycle after `cpu_halt` or `recarregar` is sampled.
- Bubbles on `host_valido` insert wait cycles with no state change.
- Reset asserted mid-load or mid-run: outputs take their reset values immediately. The partial word is discarded and previously written words remain in memory.

## Structure
- Shared package `pacote_cpu` holds:
  - the state enum (`TAM0`, `TAM1`, `RECEBE`, `ESCREVE`, `EXECUTA`, `PARADO`, `ERRO`);
  - `MEM_SIZE`;
  - `OPCODE_HALT` = 6'b111111.
- One sub-module, `montador_palavra`, assembles 4 bytes into a 32-bit word. It has inputs `clock`, `reset`, `limpa`, `byte_en`, `byte`, and outputs `palavra` and `cheia`.
- The FSM, word index, N register and address mux live in the top module.

## Test plan
- Load N=3 with words 0x0863_0001, 0x5015_000A, 0xFC00_0000 → three `mem_escrita` pulses at addresses 0,1,2 with those data; then `cpu_habilita`=1 and `mem_endereco` follows `pc`.
- N=0 → no writes; `cpu_habilita`=1 on the cycle after the 2nd byte.
- N=31 with `MEM_SIZE`=30 → `carga_erro`=1 and `host_pronto`=0; `recarregar` → `TAM0` with `carga_erro`=0.
- `host_valido` toggling every other cycle during a 2-word load → same memory contents; no byte dropped or duplicated.
- In `EXECUTA`:
  - `cpu_halt` → `PARADO` with `cpu_habilita`=0 next cycle;
  - then `recarregar` plus a load of N=1 word 0x1234_5678 → write at address 0 and the core re-enabled.
- `reset` asserted after 2 bytes of word 1 → outputs immediately at reset values; a fresh N=1 load writes address 0 correctly.

Source files
------------

// File: rtl/controlador_carga_instrucoes_pkg.sv
// pacote_cpu: shared loader state encoding, memory depth and HALT opcode
package pacote_cpu;

    localparam int MEM_SIZE = 30;
    localparam logic [5:0] OPCODE_HALT = 6'b111111;

    typedef enum logic [2:0] {
        TAM0,
        TAM1,
        RECEBE,
        ESCREVE,
        EXECUTA,
        PARADO,
        ERRO
    } estado_t;

endpackage

// File: rtl/controlador_carga_instrucoes_montador_palavra.sv
// montador_palavra: assembles four MSB-first bytes into a 32-bit word
// Ports: clock, reset (async, active-high); i_limpa clears the word and byte count;
//        i_byte_en/i_byte shift one byte in from the LSB side;
//        o_palavra is the assembled word; o_cheia flags that the 4th byte is being accepted.
module montador_palavra
    import pacote_cpu::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        i_limpa,
    input  logic        i_byte_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_palavra,
    output logic        o_cheia
);

    logic [1:0]  r_cont;
    logic [31:0] r_palavra;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cont    <= '0;
            r_palavra <= '0;
        end else if (i_limpa) begin
            r_cont    <= '0;
            r_palavra <= '0;
        end else if (i_byte_en) begin
            r_palavra <= {r_palavra[23:0], i_byte};
            r_cont    <= r_cont + 2'd1;
        end
    end

    assign o_palavra = r_palavra;
    assign o_cheia   = i_byte_en && (r_cont == 2'd3);

endmodule

// File: rtl/controlador_carga_instrucoes.sv
// controlador_carga_instrucoes: boot loader and port arbiter for instruction memory
// Ports: clock, reset (async, active-high)
//        host_dado/host_valido/host_pronto: byte stream from host (N high, N low, then N words MSB-first)
//        recarregar: restart loading from EXECUTA/PARADO/ERRO; cpu_halt: core reached HALT
//        pc: core fetch address; mem_endereco/mem_dado/mem_escrita: memory port
//        cpu_habilita: core may run; carga_erro: declared size exceeded MEM_SIZE
module controlador_carga_instrucoes
    import pacote_cpu::*;
#(
    parameter int MEM_SIZE   = pacote_cpu::MEM_SIZE,
    parameter int ADDR_WIDTH = 26
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            host_dado,
    input  logic                  host_valido,
    output logic                  host_pronto,
    input  logic                  recarregar,
    input  logic                  cpu_halt,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] mem_endereco,
    output logic [31:0]           mem_dado,
    output logic                  mem_escrita,
    output logic                  cpu_habilita,
    output logic                  carga_erro
);

    estado_t     r_estado, w_prox;
    logic [15:0] r_n;
    logic [15:0] r_indice;
    logic [15:0] w_n_novo;
    logic        w_xfer;
    logic        w_cheia;
    logic        w_ultima;
    logic [31:0] w_palavra;

    assign w_xfer   = host_valido && host_pronto;
    assign w_n_novo = {r_n[15:8], host_dado};
    assign w_ultima = r_indice == (r_n - 16'd1);

    montador_palavra u_montador (
        .clock     (clock),
        .reset     (reset),
        .i_limpa   (r_estado == TAM0),
        .i_byte_en (w_xfer && (r_estado == RECEBE)),
        .i_byte    (host_dado),
        .o_palavra (w_palavra),
        .o_cheia   (w_cheia)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_estado <= TAM0;
        else       r_estado <= w_prox;
    end

    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            TAM0:    if (w_xfer) w_prox = TAM1;
            TAM1:    if (w_xfer) w_prox = (w_n_novo == 16'd0) ? EXECUTA :
                                          (w_n_novo > 16'(MEM_SIZE)) ? ERRO : RECEBE;
            RECEBE:  if (w_cheia) w_prox = ESCREVE;
            ESCREVE: w_prox = w_ultima ? EXECUTA : RECEBE;
            // reload outranks halt when both arrive together
            EXECUTA: w_prox = recarregar ? TAM0 : (cpu_halt ? PARADO : EXECUTA);
            PARADO:  if (recarregar) w_prox = TAM0;
            ERRO:    if (recarregar) w_prox = TAM0;
            default: w_prox = TAM0;
        endcase
    end

    // size and index are wiped on every entry into TAM0 so a reload starts clean
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_n      <= '0;
            r_indice <= '0;
        end else if (w_prox == TAM0 && r_estado != TAM0) begin
            r_n      <= '0;
            r_indice <= '0;
        end else begin
            if (w_xfer && r_estado == TAM0) r_n[15:8] <= host_dado;
            if (w_xfer && r_estado == TAM1) r_n[7:0]  <= host_dado;
            if (r_estado == ESCREVE)        r_indice  <= r_indice + 16'd1;
        end
    end

    always_comb begin
        host_pronto  = (r_estado == TAM0) || (r_estado == TAM1) || (r_estado == RECEBE);
        mem_escrita  = r_estado == ESCREVE;
        cpu_habilita = r_estado == EXECUTA;
        carga_erro   = r_estado == ERRO;
        mem_dado     = w_palavra;
        mem_endereco = (r_estado == EXECUTA || r_estado == PARADO) ? pc : ADDR_WIDTH'(r_indice);
    end

endmodule

// File: tb/tb_controlador_carga_instrucoes.sv
// tb_controlador_carga_instrucoes: directed self-checking bench for the loader
module tb_controlador_carga_instrucoes;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  host_dado = '0;
    logic        host_valido = 1'b0;
    logic        host_pronto;
    logic        recarregar = 1'b0;
    logic        cpu_halt = 1'b0;
    logic [25:0] pc = '0;
    logic [25:0] mem_endereco;
    logic [31:0] mem_dado;
    logic        mem_escrita;
    logic        cpu_habilita;
    logic        carga_erro;

    int n_cmp = 0;
    int n_err = 0;
    int n_wr  = 0;
    logic [31:0] mem [0:63];

    controlador_carga_instrucoes dut (
        .clock        (clock),
        .reset        (reset),
        .host_dado    (host_dado),
        .host_valido  (host_valido),
        .host_pronto  (host_pronto),
        .recarregar   (recarregar),
        .cpu_halt     (cpu_halt),
        .pc           (pc),
        .mem_endereco (mem_endereco),
        .mem_dado     (mem_dado),
        .mem_escrita  (mem_escrita),
        .cpu_habilita (cpu_habilita),
        .carga_erro   (carga_erro)
    );

    always #5 clock = ~clock;

    // instruction memory seen by the loader
    always @(posedge clock) begin
        if (mem_escrita === 1'b1) begin
            mem[mem_endereco[5:0]] <= mem_dado;
            n_wr <= n_wr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bolha);
        int k;
        if (bolha) begin
            host_valido = 1'b0;
            tick();
        end
        host_dado   = b;
        host_valido = 1'b1;
        k = 0;
        while (host_pronto !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        if (k >= 20) chk("pronto_timeout", {31'd0, host_pronto}, 32'd1);
        tick();
        host_valido = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic [25:0] addr, input bit bolha);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], bolha);
        chk("escreve_strobe", {31'd0, mem_escrita}, 32'd1);
        chk("escreve_addr", {6'd0, mem_endereco}, {6'd0, addr});
        chk("escreve_dado", mem_dado, w);
        chk("escreve_pronto", {31'd0, host_pronto}, 32'd0);
        tick();
    endtask

    initial begin
        int wr0;
        for (int i = 0; i < 64; i++) mem[i] = 32'hEEEE_EEEE;
        #2;
        chk("rst_pronto", {31'd0, host_pronto}, 32'd1);
        chk("rst_escrita", {31'd0, mem_escrita}, 32'd0);
        chk("rst_dado", mem_dado, 32'd0);
        chk("rst_endereco", {6'd0, mem_endereco}, 32'd0);
        chk("rst_habilita", {31'd0, cpu_habilita}, 32'd0);
        chk("rst_erro", {31'd0, carga_erro}, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // N=3 load
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_word(32'h0863_0001, 26'd0, 0);
        send_word(32'h5015_000A, 26'd1, 0);
        chk("n3_hab_early", {31'd0, cpu_habilita}, 32'd0);
        send_word(32'hFC00_0000, 26'd2, 0);
        chk("n3_habilita", {31'd0, cpu_habilita}, 32'd1);
        pc = 26'h0000155;
        #1;
        chk("n3_pc_mux", {6'd0, mem_endereco}, 32'h155);
        chk("n3_mem0", mem[0], 32'h0863_0001);
        chk("n3_mem1", mem[1], 32'h5015_000A);
        chk("n3_mem2", mem[2], 32'hFC00_0000);
        chk("n3_wrcount", n_wr, 32'd3);

        // halt then reload with N=1
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        chk("halt_habilita", {31'd0, cpu_habilita}, 32'd0);
        chk("halt_pronto", {31'd0, host_pronto}, 32'd0);
        chk("halt_pc_mux", {6'd0, mem_endereco}, 32'h155);
        recarregar = 1'b1;
        tick();
        recarregar = 1'b0;
        chk("reload_pronto", {31'd0, host_pronto}, 32'd1);
        chk("reload_endereco", {6'd0, mem_endereco}, 32'd0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(32'h1234_5678, 26'd0, 0);
        chk("reload_habilita", {31'd0, cpu_habilita}, 32'd1);
        chk("reload_mem0", mem[0], 32'h1234_5678);
        chk("reload_mem1_kept", mem[1], 32'h5015_000A);

        // halt and reload together: reload wins
        cpu_halt   = 1'b1;
        recarregar = 1'b1;
        tick();
        cpu_halt   = 1'b0;
        recarregar = 1'b0;
        chk("both_pronto", {31'd0, host_pronto}, 32'd1);
        chk("both_habilita", {31'd0, cpu_habilita}, 32'd0);

        // N=0: no writes, run right after the low byte
        wr0 = n_wr;
        send_byte(8'h00, 0);
        chk("n0_hab_early", {31'd0, cpu_habilita}, 32'd0);
        send_byte(8'h00, 0);
        chk("n0_habilita", {31'd0, cpu_habilita}, 32'd1);
        chk("n0_nowrite", n_wr, wr0);

        // N=31 exceeds capacity
        recarregar = 1'b1;
        tick();
        recarregar = 1'b0;
        send_byte(8'h00, 0);
        send_byte(8'h1F, 0);
        chk("n31_erro", {31'd0, carga_erro}, 32'd1);
        chk("n31_pronto", {31'd0, host_pronto}, 32'd0);
        chk("n31_habilita", {31'd0, cpu_habilita}, 32'd0);
        recarregar = 1'b1;
        tick();
        recarregar = 1'b0;
        chk("n31_clr_erro", {31'd0, carga_erro}, 32'd0);
        chk("n31_clr_pronto", {31'd0, host_pronto}, 32'd1);

        // N=30 is exactly the capacity and must be accepted
        send_byte(8'h00, 0);
        send_byte(8'h1E, 0);
        chk("n30_erro", {31'd0, carga_erro}, 32'd0);
        chk("n30_pronto", {31'd0, host_pronto}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // N=2 with bubbles on host_valido
        send_byte(8'h00, 1);
        send_byte(8'h02, 1);
        send_word(32'hDEAD_BEEF, 26'd0, 1);
        send_word(32'h0102_0304, 26'd1, 1);
        chk("bub_habilita", {31'd0, cpu_habilita}, 32'd1);
        chk("bub_mem0", mem[0], 32'hDEAD_BEEF);
        chk("bub_mem1", mem[1], 32'h0102_0304);

        // reset mid-load, then fresh N=1
        recarregar = 1'b1;
        tick();
        recarregar = 1'b0;
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_word(32'hCAFE_BABE, 26'd0, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_pronto", {31'd0, host_pronto}, 32'd1);
        chk("mid_rst_escrita", {31'd0, mem_escrita}, 32'd0);
        chk("mid_rst_dado", mem_dado, 32'd0);
        chk("mid_rst_endereco", {6'd0, mem_endereco}, 32'd0);
        chk("mid_rst_habilita", {31'd0, cpu_habilita}, 32'd0);
        reset = 1'b0;
        tick();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(32'h0BAD_F00D, 26'd0, 0);
        chk("fresh_habilita", {31'd0, cpu_habilita}, 32'd1);
        chk("fresh_mem0", mem[0], 32'h0BAD_F00D);
        chk("fresh_mem1_kept", mem[1], 32'h0102_0304);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
